// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory path (dmar, dmem_ctrl, control unit).
// Contents:
//   DMEM_ADDR_W / DMEM_DATA_W : default address and pixel widths
//   ST_IDLE / ST_ISSUE / ST_RD_WAIT : access FSM state encodings
//   wait_cnt_w()              : width of a down-counter that must hold a read latency
package dmem_pkg;

  localparam int DMEM_ADDR_W = 19;
  localparam int DMEM_DATA_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  // Bits needed to hold the value lat (counter loads lat and counts down to 1).
  function automatic int wait_cnt_w(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Loadable down-counter timing the SRAM read latency.
// Ports:
//   clk     in  clock, rising edge
//   RST     in  asynchronous active-high reset (count -> 0)
//   load_i  in  load the counter with MEM_LAT
//   dec_i   in  decrement by one (saturates at 0)
//   last_o  out count == 1, i.e. the final wait cycle
module dmem_wait_cnt
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  localparam int CNT_W = wait_cnt_w(MEM_LAT);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(MEM_LAT);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: accepts a read or write from the control unit
// (address from the DMAR, byte from the data register), performs one access on the
// synchronous pixel SRAM and returns read data with a one-cycle done pulse.
// Optional build macro: DMEM_BOUNDS_CHECK_EN -- reject addresses >= MEM_DEPTH without
// touching the SRAM, reporting err together with done. Undefined: err is always 0.
// Ports:
//   clk, RST            clock (rising edge), asynchronous active-high reset
//   rd_req, wr_req      access requests, sampled only while idle (write wins if both)
//   addr_in, wr_data    address / write byte, captured on acceptance
//   busy                access in progress, requests ignored
//   done, err           one-cycle completion pulse, out-of-range flag valid with done
//   rd_data             last read byte, held until the next read completes
//   mem_en, mem_we      SRAM enable (one cycle per access) and write enable
//   mem_addr, mem_wdata SRAM address (stable for the whole access) and write data
//   mem_rdata           SRAM read data, valid MEM_LAT cycles after the mem_en cycle
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMEM_ADDR_W,
  parameter int unsigned DATA_W    = DMEM_DATA_W,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MEM_DEPTH = 262144
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic cnt_load, cnt_dec, cnt_last;
  logic addr_oob;

  // Compared at 64 bits so MEM_DEPTH may exceed the address range.
  assign addr_oob = BOUNDS_EN && (64'(addr_in) >= 64'(MEM_DEPTH));

  dmem_wait_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_wait_cnt (
    .clk    (clk),
    .RST    (RST),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .last_o (cnt_last)
  );

  // NOTE: every signal gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_req || rd_req) begin
          if (addr_oob) begin
            // Rejected without an SRAM cycle; completion reported immediately.
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            busy_d      = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = wr_req;  // a simultaneous read is dropped
            mem_addr_d  = addr_in;
            mem_wdata_d = wr_data;
          end
        end
      end

      ST_ISSUE: begin
        // mem_we_q still holds the accepted operation during the issue cycle.
        if (mem_we_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_RD_WAIT;
          cnt_load = 1'b1;
        end
      end

      ST_RD_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          rd_data_d = mem_rdata;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: behavioural SRAM with fixed read latency,
// transaction-level expectations derived from the access timeline, directed steps
// followed by randomized accesses. Build with DMEM_BOUNDS_CHECK_EN to match an RTL
// built with the bounds check.
module tb_dmem_ctrl;

  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_LAT   = 2;
  localparam int unsigned MEM_DEPTH = 262144;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              RST;
  logic              rd_req, wr_req;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wr_data;
  logic              busy, done, err, mem_en, mem_we;
  logic [DATA_W-1:0] rd_data, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;

  int errors = 0;
  int checks = 0;

  dmem_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LAT   (MEM_LAT),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr_in   (addr_in),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Contents of a never-written location, shared by SRAM model and reference.
  function automatic logic [7:0] init_val(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // ---------------- behavioural SRAM ----------------
  typedef struct {
    int         due;
    logic [7:0] data;
  } ret_t;

  logic [7:0] sram [logic [ADDR_W-1:0]];
  ret_t       rq [$];
  int         cyc = 0;

  always @(posedge clk) cyc++;

  // Data for an enable seen in cycle c is presented throughout cycle c+MEM_LAT;
  // garbage otherwise so a mistimed sample is visible.
  always @(negedge clk) begin
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mem_rdata = rq[0].data;
      void'(rq.pop_front());
    end else begin
      mem_rdata = 8'($urandom);
    end
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) begin
        sram[mem_addr] = mem_wdata;
      end else begin
        rq.push_back('{due: cyc + int'(MEM_LAT),
                       data: sram.exists(mem_addr) ? sram[mem_addr] : init_val(mem_addr)});
      end
    end
  end

  // ---------------- reference state ----------------
  logic [7:0] shadow [logic [ADDR_W-1:0]];
  logic [7:0] exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    addr_in = '0;
    wr_data = '0;
  endtask

  // One access starting in the current (idle) cycle. Returns positioned in the
  // done cycle with requests low, so the caller may issue back-to-back.
  task automatic do_access(input bit wr, input bit rd, input logic [ADDR_W-1:0] a,
                           input logic [7:0] d, input bit noise, input string tag);
    bit         oob;
    int         len;
    logic [7:0] new_rd;
    oob    = BOUNDS_EN && (int'(a) >= int'(MEM_DEPTH));
    len    = oob ? 1 : (wr ? 2 : 2 + int'(MEM_LAT));
    new_rd = exp_rd;
    if (!oob && !wr && rd) new_rd = shadow.exists(a) ? shadow[a] : init_val(a);

    wr_req  = wr;
    rd_req  = rd;
    addr_in = a;
    wr_data = d;
    for (int k = 1; k <= len; k++) begin
      tick();
      clear_inputs();
      check($sformatf("%s busy c%0d", tag, k),   busy,   (k < len) && !oob);
      check($sformatf("%s done c%0d", tag, k),   done,   k == len);
      check($sformatf("%s err c%0d", tag, k),    err,    (k == len) && oob);
      check($sformatf("%s mem_en c%0d", tag, k), mem_en, (k == 1) && !oob);
      check($sformatf("%s mem_we c%0d", tag, k), mem_we, (k == 1) && !oob && wr);
      check($sformatf("%s rd_data c%0d", tag, k), rd_data, (k == len) ? new_rd : exp_rd);
      if (!oob) check($sformatf("%s mem_addr c%0d", tag, k), mem_addr, a);
      if (!oob && wr && k == 1) check($sformatf("%s mem_wdata", tag), mem_wdata, d);
      if (noise && k < len) begin
        rd_req  = 1'($urandom);
        wr_req  = 1'($urandom);
        addr_in = ADDR_W'($urandom);
        wr_data = 8'($urandom);
      end
    end
    exp_rd = new_rd;
    if (!oob && wr) shadow[a] = d;
  endtask

  logic [ADDR_W-1:0] pool [4];

  initial begin
    pool = '{19'h00010, 19'h00011, 19'h3FFFF, 19'h7FFFF};
    clear_inputs();

    // Reset state
    RST = 1'b1;
    tick();
    tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst mem_en", mem_en, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst rd_data", rd_data, 0);
    RST = 1'b0;
    tick();

    // 1. write 0xA5 to 0x00010
    do_access(1'b1, 1'b0, 19'h00010, 8'hA5, 1'b0, "wr1");
    tick();
    // 2. read it back
    do_access(1'b0, 1'b1, 19'h00010, 8'h00, 1'b0, "rd2");
    check("rd2 value", rd_data, 8'hA5);
    tick();
    // 3. simultaneous read and write: write only, rd_data unchanged
    do_access(1'b1, 1'b1, 19'h00020, 8'h3C, 1'b0, "both3");
    tick();
    check("both3 single done", done, 0);
    check("both3 no mem_en", mem_en, 0);
    // 4. requests during busy ignored, request in done cycle accepted
    do_access(1'b0, 1'b1, 19'h00020, 8'h00, 1'b1, "busy4a");
    do_access(1'b0, 1'b1, 19'h00010, 8'h00, 1'b1, "busy4b");
    tick();

    // 5. reset while waiting for read data
    rd_req  = 1'b1;
    addr_in = 19'h00123;
    tick();
    clear_inputs();
    check("rst5 issue", mem_en, 1);
    tick();
    check("rst5 waiting", busy, 1);
    #2 RST = 1'b1;
    #1;
    check("rst5 busy", busy, 0);
    check("rst5 done", done, 0);
    check("rst5 mem_en", mem_en, 0);
    check("rst5 mem_we", mem_we, 0);
    check("rst5 mem_addr", mem_addr, 0);
    check("rst5 mem_wdata", mem_wdata, 0);
    check("rst5 rd_data", rd_data, 0);
    check("rst5 err", err, 0);
    exp_rd = '0;
    tick();
    RST = 1'b0;
    for (int k = 0; k < int'(MEM_LAT) + 3; k++) begin
      tick();
      check($sformatf("rst5 post done %0d", k), done, 0);
      check($sformatf("rst5 post rd_data %0d", k), rd_data, 0);
    end

    // 6. address at MEM_DEPTH
    do_access(1'b0, 1'b1, 19'h40000, 8'h00, 1'b0, "oob6");
    tick();

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      do_access(op != 0, op != 1, pool[$urandom_range(0, 3)], 8'($urandom),
                1'($urandom), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check($sformatf("rnd%0d idle done", n), done, 0);
        check($sformatf("rnd%0d idle busy", n), busy, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
